// File: rtl/fuzz_pkg.sv
// fuzz_pkg: shared types, constants and arithmetic helpers for the fuzzy edge stage.
package fuzz_pkg;
    localparam int MU_W = 10;
    localparam int MU_ONE = 256;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    typedef struct packed {
        logic brd;
        logic sof;
        logic eof;
    } side_t;

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return a > b ? a - b : b - a;
    endfunction

    // Linear ramp from 0 at t_lo up to MU_ONE over 2^slope_sh gradient steps.
    function automatic logic [8:0] fuzzify(input logic [7:0] g, input int t_lo, input int slope_sh);
        int d;
        d = int'(g) - t_lo;
        return d <= 0 ? 9'd0 : d >= (1 << slope_sh) ? 9'(MU_ONE) : 9'((d << 8) >> slope_sh);
    endfunction

    function automatic logic [8:0] mu_min(input logic [8:0] a, input logic [8:0] b);
        return a < b ? a : b;
    endfunction

    function automatic logic [8:0] mu_max(input logic [8:0] a, input logic [8:0] b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/fuzz_line_buffer.sv
// fuzz_line_buffer: one image line of 8-bit pixels; reads the old word while the new one is written.
module fuzz_line_buffer
    import fuzz_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW = $clog2(DEPTH)
)(
    input  logic          clk,
    input  logic          i_en,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_rdata
);
    logic [7:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk)
        if (i_en) r_mem[i_addr] <= i_wdata;
endmodule

// File: rtl/fuzz_infer.sv
// fuzz_infer: 3x3 window gradients, LOW/HIGH fuzzification and three-rule inference.
// Input register then four stages (window, gradient, fuzzify, rules); one global stall enable.
module fuzz_infer
    import fuzz_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int T_LO = 16,
    parameter int SLOPE_SH = 5
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pix_valid,
    output logic            pix_ready,
    input  logic [7:0]      pix_data,
    input  logic            pix_sof,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            m_sof,
    output logic            m_eof,
    output logic [MU_W-1:0] Mmin,
    output logic [MU_W-1:0] Mmid,
    output logic [MU_W-1:0] Mmax
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_t r_state;
    logic [CW-1:0] r_col, w_col, r0_col;
    logic [RW-1:0] r_row, w_row;
    logic w_en, w_acc, w_last_col, w_last_row;
    logic r0_valid, r1_valid, r2_valid, r3_valid;
    side_t w_side, r0_side, r1_side, r2_side, r3_side;
    logic [7:0] r0_pix, w_lb1, w_lb2, r2_gx, r2_gy;
    logic [7:0] r_win [3][3];
    logic [8:0] r3_hx, r3_hy, w_lx, w_ly;

    assign w_en = !m_valid || m_ready;
    assign pix_ready = w_en && rst_n;
    assign w_acc = pix_valid && pix_ready && (pix_sof || r_state == S_RUN);
    // A start-of-frame pixel is always pixel (0,0), even mid-frame.
    assign w_col = pix_sof ? '0 : r_col;
    assign w_row = pix_sof ? '0 : r_row;
    assign w_last_col = w_col == CW'(IMG_W - 1);
    assign w_last_row = w_row == RW'(IMG_H - 1);
    assign w_side = '{brd: w_row < RW'(2) || w_col < CW'(2), sof: w_row == '0 && w_col == '0, eof: w_last_row && w_last_col};
    assign w_lx = 9'(MU_ONE) - r3_hx;
    assign w_ly = 9'(MU_ONE) - r3_hy;

    always_ff @(posedge clk)
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_row <= '0;
            r_col <= '0;
        end else if (w_acc) begin
            r_col <= w_last_col ? '0 : w_col + 1'b1;
            r_row <= w_last_col ? w_row + 1'b1 : w_row;
            r_state <= w_last_col && w_last_row ? S_IDLE : S_RUN;
        end

    always_ff @(posedge clk)
        if (!rst_n) {r0_valid, r1_valid, r2_valid, r3_valid} <= '0;
        else if (w_en) {r0_valid, r1_valid, r2_valid, r3_valid} <= {w_acc, r0_valid, r1_valid, r2_valid};

    fuzz_line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
        .clk(clk), .i_en(w_en && r0_valid), .i_addr(r0_col), .i_wdata(r0_pix), .o_rdata(w_lb1)
    );

    fuzz_line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb2 (
        .clk(clk), .i_en(w_en && r0_valid), .i_addr(r0_col), .i_wdata(w_lb1), .o_rdata(w_lb2)
    );

    // Window row 0 is the oldest line; column 2 is the newest pixel.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r0_pix <= pix_data;
            r0_col <= w_col;
            r0_side <= w_side;
        end
        if (w_en && r0_valid) begin
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= r_win[i][2];
            end
            r_win[0][2] <= w_lb2;
            r_win[1][2] <= w_lb1;
            r_win[2][2] <= r0_pix;
            r1_side <= r0_side;
        end
        if (w_en && r1_valid) begin
            r2_gx <= abs_diff(r_win[1][2], r_win[1][0]);
            r2_gy <= abs_diff(r_win[2][1], r_win[0][1]);
            r2_side <= r1_side;
        end
        if (w_en && r2_valid) begin
            r3_hx <= fuzzify(r2_gx, T_LO, SLOPE_SH);
            r3_hy <= fuzzify(r2_gy, T_LO, SLOPE_SH);
            r3_side <= r2_side;
        end
    end

    always_ff @(posedge clk)
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_sof <= 1'b0;
            m_eof <= 1'b0;
            Mmin <= '0;
            Mmid <= '0;
            Mmax <= '0;
        end else if (w_en) begin
            m_valid <= r3_valid;
            m_sof <= r3_valid && r3_side.sof;
            m_eof <= r3_valid && r3_side.eof;
            if (r3_valid) begin
                Mmin <= r3_side.brd ? MU_W'(MU_ONE) : MU_W'(mu_min(w_lx, w_ly));
                Mmid <= r3_side.brd ? '0 : MU_W'(mu_max(mu_min(r3_hx, w_ly), mu_min(w_lx, r3_hy)));
                Mmax <= r3_side.brd ? '0 : MU_W'(mu_min(r3_hx, r3_hy));
            end
        end
endmodule

// File: tb/tb_fuzz_infer.sv
// tb_fuzz_infer: scoreboard bench; a frame-level reference model queues expected triples,
// a monitor pops and compares on every output handshake.
module tb_fuzz_infer;
    localparam int W = 8;
    localparam int H = 4;
    localparam int T_LO = 16;
    localparam int SH = 5;

    logic clk = 1'b0, rst_n = 1'b0, pix_valid = 1'b0, pix_sof = 1'b0, m_ready = 1'b1;
    logic pix_ready, m_valid, m_sof, m_eof;
    logic [7:0] pix_data = 8'd0;
    logic [9:0] Mmin, Mmid, Mmax;

    fuzz_infer #(.IMG_W(W), .IMG_H(H), .T_LO(T_LO), .SLOPE_SH(SH)) dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_sof(pix_sof), .m_valid(m_valid), .m_ready(m_ready),
        .m_sof(m_sof), .m_eof(m_eof), .Mmin(Mmin), .Mmid(Mmid), .Mmax(Mmax)
    );

    always #5 clk = ~clk;

    typedef struct {
        int  mn;
        int  md;
        int  mx;
        bit  sof;
        bit  eof;
    } res_t;

    res_t q[$];
    int errors = 0, checks = 0, cyc = 0, n_res = 0, bp_mode = 0;
    int sof_acc = -1, sof_out = -1;
    bit m_run = 1'b0;
    int m_r = 0, m_c = 0;
    int img[H][W];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return a < b ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return a > b ? a : b;
    endfunction

    function automatic int iabs(input int a);
        return a < 0 ? -a : a;
    endfunction

    function automatic int fz(input int g);
        if (g <= T_LO) return 0;
        if (g >= T_LO + (1 << SH)) return 256;
        return (g - T_LO) * 256 / (1 << SH);
    endfunction

    // Frame-level reference: position tracking plus the rule evaluation on the stored image.
    task automatic model_accept(input int p, input bit sof);
        res_t e;
        int r, c, hx, hy;
        if (!sof && !m_run) return;
        if (sof) begin
            m_r = 0;
            m_c = 0;
            sof_acc = cyc;
        end
        r = m_r;
        c = m_c;
        img[r][c] = p;
        if (r < 2 || c < 2) begin
            e.mn = 256; e.md = 0; e.mx = 0;
        end else begin
            hx = fz(iabs(img[r-1][c] - img[r-1][c-2]));
            hy = fz(iabs(img[r][c-1] - img[r-2][c-1]));
            e.mn = imin(256 - hx, 256 - hy);
            e.md = imax(imin(hx, 256 - hy), imin(256 - hx, hy));
            e.mx = imin(hx, hy);
        end
        e.sof = (r == 0 && c == 0);
        e.eof = (r == H - 1 && c == W - 1);
        q.push_back(e);
        m_c++;
        if (m_c == W) begin
            m_c = 0;
            m_r++;
        end
        m_run = !e.eof;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int p, input bit sof);
        int t = 0;
        bit a;
        pix_valid = 1'b1;
        pix_data = p[7:0];
        pix_sof = sof;
        do begin
            #1 a = pix_ready;
            @(negedge clk);
            t++;
        end while (!a && t < 200);
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        chk("pixel accepted", int'(a), 1);
        if (a) model_accept(p, sof);
    endtask

    function automatic int pix_of(input int kind, input int r, input int c);
        case (kind)
            0: return 100;
            1: return c < 4 ? 0 : 200;
            2: return 20 * (r + c);
            default: return int'($urandom_range(0, 60));
        endcase
    endfunction

    task automatic send_frame(input int kind, input bit gaps);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                send(pix_of(kind, r, c), r == 0 && c == 0);
                if (gaps) idle(int'($urandom_range(0, 2)));
            end
    endtask

    task automatic drain_check(input string name, input int expn);
        int t = 0;
        while (q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        idle(2);
        chk({name, " drained"}, q.size(), 0);
        chk({name, " result count"}, n_res, expn);
    endtask

    task automatic stall_test();
        int t = 0;
        repeat (12) @(negedge clk);
        bp_mode = 2;
        idle(2);
        #3;
        while (!m_valid && t < 20) begin
            @(negedge clk);
            #3;
            t++;
        end
        chk("stall m_valid present", int'(m_valid), 1);
        for (int k = 0; k < 10; k++) begin
            chk("stall m_valid held", int'(m_valid), 1);
            chk("stall pix_ready low", int'(pix_ready), 0);
            if (q.size() > 0) begin
                chk("stall Mmin held", int'(Mmin), q[0].mn);
                chk("stall Mmid held", int'(Mmid), q[0].md);
                chk("stall Mmax held", int'(Mmax), q[0].mx);
            end else chk("stall queue has head", 0, 1);
            @(negedge clk);
            #3;
        end
        bp_mode = 0;
    endtask

    initial forever begin
        @(negedge clk);
        m_ready = bp_mode == 0 ? 1'b1 : bp_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    initial forever begin
        res_t e;
        @(negedge clk);
        #2;
        if (rst_n && m_valid && m_ready) begin
            if (q.size() == 0) chk("unexpected result", 1, 0);
            else begin
                e = q.pop_front();
                checks++;
                if (int'(Mmin) != e.mn || int'(Mmid) != e.md || int'(Mmax) != e.mx || m_sof != e.sof || m_eof != e.eof) begin
                    errors++;
                    $display("FAIL result: got %0d/%0d/%0d sof=%0d eof=%0d expected %0d/%0d/%0d sof=%0d eof=%0d",
                             Mmin, Mmid, Mmax, m_sof, m_eof, e.mn, e.md, e.mx, e.sof, e.eof);
                end
            end
            if (m_sof) sof_out = cyc;
            n_res++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset pix_ready", int'(pix_ready), 0);
        chk("reset m_valid", int'(m_valid), 0);
        chk("reset m_sof", int'(m_sof), 0);
        chk("reset m_eof", int'(m_eof), 0);
        chk("reset Mmin", int'(Mmin), 0);
        chk("reset Mmid", int'(Mmid), 0);
        chk("reset Mmax", int'(Mmax), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        n_res = 0;
        send_frame(0, 1'b0);
        drain_check("flat", W * H);
        n_res = 0;
        send_frame(1, 1'b0);
        drain_check("step", W * H);
        n_res = 0;
        send_frame(2, 1'b0);
        drain_check("ramp", W * H);

        n_res = 0;
        fork
            send_frame(2, 1'b0);
            stall_test();
        join
        drain_check("backpressure", W * H);

        n_res = 0;
        bp_mode = 1;
        repeat (3) send_frame(3, 1'b1);
        drain_check("random", 3 * W * H);
        bp_mode = 0;
        idle(2);

        n_res = 0;
        repeat (5) send(int'($urandom_range(0, 255)), 1'b0);
        for (int k = 0; k < 10; k++) send(pix_of(3, 0, 0), k == 0);
        send_frame(3, 1'b0);
        drain_check("resync", 10 + W * H);
        chk("sof latency", sof_out - sof_acc, 4);

        n_res = 0;
        for (int k = 0; k < 15; k++) send(pix_of(3, 0, 0), k == 0);
        bp_mode = 2;
        idle(2);
        rst_n = 1'b0;
        q.delete();
        m_run = 1'b0;
        #1 chk("mid reset pix_ready", int'(pix_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid reset m_valid", int'(m_valid), 0);
        chk("mid reset m_sof", int'(m_sof), 0);
        chk("mid reset m_eof", int'(m_eof), 0);
        chk("mid reset Mmin", int'(Mmin), 0);
        chk("mid reset Mmid", int'(Mmid), 0);
        chk("mid reset Mmax", int'(Mmax), 0);
        bp_mode = 0;
        n_res = 0;
        repeat (5) send(int'($urandom_range(0, 255)), 1'b0);
        idle(10);
        chk("no results before sof", n_res, 0);
        send_frame(3, 1'b1);
        drain_check("after reset", W * H);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
